d_cache_ctrl: RTL

D_CACHE_CTRL -- requirements
Module: d_cache_ctrl

---
 rtl/d_cache_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/d_cache_ctrl.sv
// d_cache_ctrl: one-outstanding data-memory access controller between decode and act stages.
// Build option NAND_CPU_DCACHE_HIT_BUF_EN adds a one-entry load hit buffer (valid, tag, data).
module d_cache_ctrl #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_address,
  input  logic              i_mem_op,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_flush,
  output logic              o_stall,
  output logic              o_load_valid,
  output logic [DATA_W-1:0] o_load_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        o_dbg_state
);

  // Handshake: mem_req is a valid that stays high with a stable mem_addr/mem_we/mem_wdata
  // until mem_ack is seen high in the same cycle; o_stall is the not-ready seen upstream.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                kill_q, kill_d;
  logic [DATA_W-1:0]   load_data_q, load_data_d;
  logic                stall_raw;
  logic                hit;
  logic [DATA_W-1:0]   hit_data;
  logic                kill_now;

  // A flush arriving in the same cycle as mem_ack still kills the load.
  assign kill_now = kill_q | i_flush;

`ifdef NAND_CPU_DCACHE_HIT_BUF_EN
  logic                buf_valid_q, buf_valid_d;
  logic [DATA_W-1:0]   buf_tag_q, buf_tag_d;
  logic [DATA_W-1:0]   buf_data_q, buf_data_d;

  assign hit      = (state_q == ST_IDLE) && i_valid && !i_flush && !i_mem_op &&
                    buf_valid_q && (buf_tag_q == i_address);
  assign hit_data = buf_data_q;

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
    if (state_q == ST_REQ && mem_ack) begin
      if (!we_q && !kill_now) begin
        buf_valid_d = 1'b1;
        buf_tag_d   = addr_q;
        buf_data_d  = mem_rdata;
      end else if (we_q && buf_valid_q && buf_tag_q == addr_q) begin
        // Stores keep the buffer coherent even when killed, since memory is written anyway.
        buf_data_d  = wdata_q;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    kill_d       = kill_q;
    load_data_d  = load_data_q;
    stall_raw    = 1'b0;
    mem_req      = 1'b0;
    o_load_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        kill_d = 1'b0;
        if (hit) begin
          o_load_valid = 1'b1;
          load_data_d  = hit_data;
        end else if (i_valid && !i_flush) begin
          stall_raw = 1'b1;
          state_d   = ST_REQ;
          we_d      = i_mem_op;
          addr_d    = i_address;
          wdata_d   = i_data;
        end
      end
      ST_REQ: begin
        stall_raw = 1'b1;
        mem_req   = 1'b1;
        if (i_flush) kill_d = 1'b1;
        if (mem_ack) begin
          state_d = ST_DONE;
          if (!we_q && !kill_now) load_data_d = mem_rdata;
        end
      end
      ST_DONE: begin
        o_load_valid = !we_q && !kill_q;
        kill_d       = 1'b0;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        kill_d  = 1'b0;
      end
    endcase
  end

  // Reset overrides the combinational stall so nothing upstream is held while in reset.
  assign o_stall     = stall_raw & n_rst;
  assign o_load_data = hit ? hit_data : load_data_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign o_dbg_state = state_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      kill_q      <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      kill_q      <= kill_d;
      load_data_q <= load_data_d;
    end
  end

endmodule
